// File: rtl/ps2_key_ctrl.sv
// PS/2 key sequencer: pops receiver FIFO bytes, decodes make/break/extended codes,
// filters typematic repeats and presents the single held key to the display path.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ps2_ready,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_overflow,
    output logic             nextdata_n,
    output logic [7:0]       scan_code,
    output logic             ext_key,
    output logic             key_released,
    output logic             key_event,
    output logic [CNT_W-1:0] press_count,
    output logic             err_overflow
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    byte_p0;
    logic          vld_p0;
    logic [TW-1:0] tcnt;
    logic          fetch;
    logic          do_make;
    logic          do_break;
    logic          code_ext;
    logic          held_match;

    // vld_p0 doubles as the one-cycle gap that keeps ps2_ready from being
    // re-sampled before the FIFO read pointer has moved.
    assign fetch = ps2_ready && !vld_p0;

    // Stage p0: pop strobe and byte capture
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            nextdata_n <= 1'b1;
            vld_p0     <= 1'b0;
        end else begin
            nextdata_n <= !fetch;
            vld_p0     <= fetch;
        end
    end

    always_ff @(posedge clk) begin
        if (fetch)
            byte_p0 <= ps2_data;
    end

    always_comb begin
        state_nx = state;
        do_make  = 1'b0;
        do_break = 1'b0;
        code_ext = 1'b0;
        unique case (state)
            IDLE: begin
                if (byte_p0 == 8'hE0)      state_nx = EXT;
                else if (byte_p0 == 8'hF0) state_nx = BRK;
                else                       do_make  = 1'b1;
            end
            EXT: begin
                code_ext = 1'b1;
                if (byte_p0 == 8'hE0)      state_nx = EXT;
                else if (byte_p0 == 8'hF0) state_nx = EXT_BRK;
                else begin
                    do_make  = 1'b1;
                    state_nx = IDLE;
                end
            end
            BRK: begin
                do_break = 1'b1;
                state_nx = IDLE;
            end
            EXT_BRK: begin
                code_ext = 1'b1;
                do_break = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    assign held_match = !key_released && (code_ext == ext_key) && (byte_p0 == scan_code);

    // Stage p1: decode FSM and registered key state
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state        <= IDLE;
            tcnt         <= '0;
            scan_code    <= 8'h00;
            ext_key      <= 1'b0;
            key_released <= 1'b1;
            key_event    <= 1'b0;
            press_count  <= '0;
            err_overflow <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (ps2_overflow)
                err_overflow <= 1'b1;
            if (vld_p0) begin
                tcnt  <= '0;
                state <= state_nx;
                if (do_make && !held_match) begin
                    scan_code    <= byte_p0;
                    ext_key      <= code_ext;
                    key_released <= 1'b0;
                    key_event    <= 1'b1;
                    press_count  <= press_count + 1'b1;
                end
                if (do_break && held_match) begin
                    key_released <= 1'b1;
                    key_event    <= 1'b1;
                end
            end else if (state != IDLE) begin
                // A stalled prefix is dropped silently; outputs keep their values.
                if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    state <= IDLE;
                    tcnt  <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule
